// File: rtl/game_pkg.sv
// game_pkg: shared state/mark types, board size and the ten winning lines of the 4x4 board.
package game_pkg;
  localparam int N_CELLS = 16;
  typedef enum logic [2:0] {S_TURN, S_AUTO, S_WRITE, S_CHECK, S_OVER} state_t;
  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} mark_t;
  // rows, columns, then the two diagonals
  localparam logic [3:0] WIN_LINES [10][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3},
    '{4'd4,  4'd5,  4'd6,  4'd7},
    '{4'd8,  4'd9,  4'd10, 4'd11},
    '{4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd1,  4'd5,  4'd9,  4'd13},
    '{4'd2,  4'd6,  4'd10, 4'd14},
    '{4'd3,  4'd7,  4'd11, 4'd15},
    '{4'd0,  4'd5,  4'd10, 4'd15},
    '{4'd3,  4'd6,  4'd9,  4'd12}
  };
  function automatic logic [1:0] cell_at(input logic [2*N_CELLS-1:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/win_checker.sv
// win_checker: combinational win-line and full-board detection over the 4x4 board.
module win_checker
  import game_pkg::*;
(
  input  logic [2*N_CELLS-1:0] board_i,
  output logic                 win_o,
  output mark_t                mark_o,
  output logic                 full_o
);
  always_comb begin
    win_o  = 1'b0;
    mark_o = EMPTY;
    full_o = 1'b1;
    for (int k = 0; k < N_CELLS; k++)
      if (cell_at(board_i, 4'(k)) == EMPTY) full_o = 1'b0;
    for (int l = 0; l < 10; l++)
      if (cell_at(board_i, WIN_LINES[l][0]) != EMPTY &&
          cell_at(board_i, WIN_LINES[l][0]) == cell_at(board_i, WIN_LINES[l][1]) &&
          cell_at(board_i, WIN_LINES[l][0]) == cell_at(board_i, WIN_LINES[l][2]) &&
          cell_at(board_i, WIN_LINES[l][0]) == cell_at(board_i, WIN_LINES[l][3])) begin
        win_o  = 1'b1;
        mark_o = mark_t'(cell_at(board_i, WIN_LINES[l][0]));
      end
  end
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: game sequencer owning cursor, player turn, turn timer and auto-move,
// issuing single-cycle cell writes and freezing after a win or draw until new_game.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TURN_CYCLES = 50000000,
  parameter int TW          = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_i,
  input  logic                 select_i,
  input  logic                 new_game_i,
  input  logic [2*N_CELLS-1:0] board_i,
  output logic [3:0]           cursor_o,
  output logic                 player_o,
  output logic                 wr_en_o,
  output logic [3:0]           wr_idx_o,
  output logic [1:0]           wr_mark_o,
  output logic                 sel_err_o,
  output logic                 timeout_o,
  output logic [TW-1:0]        timer_o,
  output logic                 game_over_o,
  output logic [1:0]           winner_o
);
  state_t        state_q, state_d;
  logic [3:0]    cursor_q, cursor_d, scan_q, scan_d, wr_idx_q, wr_idx_d;
  logic          player_q, player_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    winner_q, winner_d;
  logic          win, full, sel_ok;
  mark_t         win_mark;
  win_checker u_win (.board_i(board_i), .win_o(win), .mark_o(win_mark), .full_o(full));
  assign sel_ok = select_i && cell_at(board_i, cursor_q) == EMPTY;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= S_TURN;
      cursor_q <= '0;
      scan_q   <= '0;
      wr_idx_q <= '0;
      player_q <= 1'b0;
      timer_q  <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      scan_q   <= scan_d;
      wr_idx_q <= wr_idx_d;
      player_q <= player_d;
      timer_q  <= timer_d;
      winner_q <= winner_d;
    end
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    scan_d    = scan_q;
    wr_idx_d  = wr_idx_q;
    player_d  = player_q;
    timer_d   = timer_q;
    winner_d  = winner_q;
    sel_err_o = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      S_TURN: begin
        timer_d = timer_q + 1'b1;
        if (sel_ok) begin
          wr_idx_d = cursor_q;
          state_d  = S_WRITE;
        end else if (select_i) sel_err_o = 1'b1;
        else if (move_i) cursor_d = cursor_q + 4'd1;
        // a valid select on the expiry cycle beats the auto-move
        if (!sel_ok && timer_q == TW'(TURN_CYCLES - 1)) begin
          timeout_o = 1'b1;
          scan_d    = cursor_q;
          state_d   = S_AUTO;
        end
      end
      S_AUTO: begin
        if (cell_at(board_i, scan_q) == EMPTY) begin
          wr_idx_d = scan_q;
          state_d  = S_WRITE;
        end else scan_d = scan_q + 4'd1;
      end
      S_WRITE: state_d = S_CHECK;
      S_CHECK: begin
        if (win || full) begin
          winner_d = win ? win_mark : EMPTY;
          state_d  = S_OVER;
        end else begin
          player_d = ~player_q;
          timer_d  = '0;
          state_d  = S_TURN;
        end
      end
      S_OVER: begin
        if (new_game_i) begin
          state_d  = S_TURN;
          cursor_d = '0;
          scan_d   = '0;
          wr_idx_d = '0;
          player_d = 1'b0;
          timer_d  = '0;
          winner_d = '0;
        end
      end
      default: state_d = S_TURN;
    endcase
  end
  assign cursor_o    = cursor_q;
  assign player_o    = player_q;
  assign wr_en_o     = state_q == S_WRITE;
  assign wr_idx_o    = wr_idx_q;
  assign wr_mark_o   = wr_en_o ? (player_q ? P2 : P1) : EMPTY;
  assign timer_o     = timer_q;
  assign game_over_o = state_q == S_OVER;
  assign winner_o    = winner_q;
endmodule
